mouse_cursor_ctrl: RTL and testbench

Converts the PS/2 mouse byte stream into an absolute, clamped cursor position and pushes it onto the system bus. It acts as an Avalon-MM write master that sequences updates into the 10-bit cursor X and Y PIO output slaves. It sits between the PS/2 receiver and the SOPC interconnect and exposes button state directly.

---
 rtl/mouse_pkg.sv | 31 +++
 rtl/mouse_axis_accum.sv | 45 ++++
 rtl/mouse_cursor_ctrl.sv | 125 ++++++++++++
 tb/tb_mouse_cursor_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse cursor controller.
package mouse_pkg;

  localparam int MOUSE_COORD_W = 10;
  localparam int MOUSE_DELTA_W = 11;

  // Byte0 bit positions
  localparam int B0_LEFT   = 0;
  localparam int B0_RIGHT  = 1;
  localparam int B0_MIDDLE = 2;
  localparam int B0_SYNC   = 3;
  localparam int B0_XSIGN  = 4;
  localparam int B0_YSIGN  = 5;
  localparam int B0_XOVF   = 6;
  localparam int B0_YOVF   = 7;

  typedef enum logic [2:0] {
    ST_B0, ST_B1, ST_B2, ST_UPD, ST_WR_X, ST_WR_Y
  } mouse_state_t;

  typedef logic signed [MOUSE_DELTA_W-1:0] mouse_delta_t;

  // 9-bit two's complement movement widened to the accumulator width; overflow zeroes it.
  function automatic mouse_delta_t delta_from(input logic sign, input logic [7:0] mag,
                                              input logic ovf);
    mouse_delta_t d;
    d = $signed({{3{sign}}, mag});
    return ovf ? '0 : d;
  endfunction

endpackage

// File: rtl/mouse_axis_accum.sv
// One cursor axis: registered add-and-clamp into [0, MAX_VAL], optionally subtracting the delta.
module mouse_axis_accum
  import mouse_pkg::*;
#(
  parameter int MAX_VAL  = 639,
  parameter int INIT_VAL = 320,
  parameter bit INVERT   = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  mouse_delta_t             delta,
  output logic [MOUSE_COORD_W-1:0] coord,
  output logic [MOUSE_COORD_W-1:0] coord_next
);

  logic signed [MOUSE_DELTA_W-1:0] sum;

  function automatic logic [MOUSE_COORD_W-1:0] clamp(input logic signed [MOUSE_DELTA_W-1:0] v);
    if (v < 0)
      return '0;
    else if (v > MAX_VAL)
      return MOUSE_COORD_W'(MAX_VAL);
    else
      return v[MOUSE_COORD_W-1:0];
  endfunction

  // Sum is visible combinationally so the bus can present the new value in the first write cycle
  always_comb begin
    sum = '0;
    if (INVERT)
      sum = $signed({1'b0, coord}) - delta;
    else
      sum = $signed({1'b0, coord}) + delta;
    coord_next = clamp(sum);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      coord <= MOUSE_COORD_W'(INIT_VAL);
    else if (load)
      coord <= coord_next;
  end

endmodule

// File: rtl/mouse_cursor_ctrl.sv
// PS/2 packet collector and Avalon-MM write master driving the cursor X/Y PIO slaves.
module mouse_cursor_ctrl
  import mouse_pkg::*;
#(
  parameter int                X_MAX  = 639,
  parameter int                Y_MAX  = 479,
  parameter int                X_INIT = 320,
  parameter int                Y_INIT = 240,
  parameter int                ADDR_W = 16,
  parameter logic [ADDR_W-1:0] X_ADDR = 16'h0000,
  parameter logic [ADDR_W-1:0] Y_ADDR = 16'h0010
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [31:0]       m_writedata,
  input  logic              m_waitrequest,
  output logic [2:0]        buttons,
  output logic              pkt_err
);

  localparam int PAD_W = 32 - MOUSE_COORD_W;

  mouse_state_t             state;
  logic                     accept;
  logic [2:0]               hdr_btn;
  logic                     hdr_xs, hdr_ys, hdr_xo, hdr_yo;
  logic [7:0]               mag_x, mag_y;
  mouse_delta_t             dx, dy;
  logic                     load;
  logic [MOUSE_COORD_W-1:0] x_coord, x_next, y_coord, y_next;

  assign accept = rx_valid && rx_ready;
  assign load   = (state == ST_UPD);
  assign dx     = delta_from(hdr_xs, mag_x, hdr_xo);
  assign dy     = delta_from(hdr_ys, mag_y, hdr_yo);

  mouse_axis_accum #(.MAX_VAL(X_MAX), .INIT_VAL(X_INIT), .INVERT(1'b0)) u_x (
    .clk(clk), .reset_n(reset_n), .load(load), .delta(dx),
    .coord(x_coord), .coord_next(x_next)
  );

  // PS/2 +Y points up while screen +Y points down, so this axis subtracts
  mouse_axis_accum #(.MAX_VAL(Y_MAX), .INIT_VAL(Y_INIT), .INVERT(1'b1)) u_y (
    .clk(clk), .reset_n(reset_n), .load(load), .delta(dy),
    .coord(y_coord), .coord_next(y_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_WR_X;
      rx_ready     <= 1'b0;
      buttons      <= '0;
      pkt_err      <= 1'b0;
      m_chipselect <= 1'b1;
      m_write_n    <= 1'b0;
      m_address    <= X_ADDR;
      m_writedata  <= {{PAD_W{1'b0}}, MOUSE_COORD_W'(X_INIT)};
      hdr_btn      <= '0;
      hdr_xs       <= 1'b0;
      hdr_ys       <= 1'b0;
      hdr_xo       <= 1'b0;
      hdr_yo       <= 1'b0;
      mag_x        <= '0;
      mag_y        <= '0;
    end else begin
      pkt_err <= 1'b0;
      case (state)
        ST_B0: if (accept) begin
          if (rx_data[B0_SYNC]) begin
            hdr_btn <= {rx_data[B0_MIDDLE], rx_data[B0_RIGHT], rx_data[B0_LEFT]};
            hdr_xs  <= rx_data[B0_XSIGN];
            hdr_ys  <= rx_data[B0_YSIGN];
            hdr_xo  <= rx_data[B0_XOVF];
            hdr_yo  <= rx_data[B0_YOVF];
            state   <= ST_B1;
          end else begin
            pkt_err <= 1'b1;
          end
        end
        ST_B1: if (accept) begin
          mag_x <= rx_data;
          state <= ST_B2;
        end
        ST_B2: if (accept) begin
          mag_y    <= rx_data;
          rx_ready <= 1'b0;
          state    <= ST_UPD;
        end
        ST_UPD: begin
          buttons      <= hdr_btn;
          pkt_err      <= hdr_xo || hdr_yo;
          m_chipselect <= 1'b1;
          m_write_n    <= 1'b0;
          m_address    <= X_ADDR;
          m_writedata  <= {{PAD_W{1'b0}}, x_next};
          state        <= ST_WR_X;
        end
        ST_WR_X: if (!m_waitrequest) begin
          m_address   <= Y_ADDR;
          m_writedata <= {{PAD_W{1'b0}}, y_coord};
          state       <= ST_WR_Y;
        end
        ST_WR_Y: if (!m_waitrequest) begin
          m_chipselect <= 1'b0;
          m_write_n    <= 1'b1;
          m_address    <= '0;
          m_writedata  <= '0;
          rx_ready     <= 1'b1;
          state        <= ST_B0;
        end
        default: begin
          rx_ready <= 1'b1;
          state    <= ST_B0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_cursor_ctrl.sv
// Bench for mouse_cursor_ctrl: directed packets plus randomized traffic against a position model.
module tb_mouse_cursor_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic [2:0]  buttons;
  logic        pkt_err;

  mouse_cursor_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .buttons(buttons), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          err_cnt = 0;
  int          exp_err = 0;
  bit          rand_stall = 1'b0;
  logic [47:0] wq[$];

  // Reference state
  int       mx = 320;
  int       my = 240;
  bit [2:0] mbtn = 3'b000;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    else
      n_pass++;
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // Completed bus transfers and error pulses, observed mid-cycle
  always @(negedge clk) begin
    if (reset_n && m_chipselect && !m_write_n && !m_waitrequest)
      wq.push_back({m_address, m_writedata});
    if (reset_n && pkt_err)
      err_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    m_waitrequest = rand_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 300) begin
      cyc();
      n++;
    end
    chk("byte_accept", rx_ready, 1);
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic send_junk(input logic [7:0] b);
    exp_err++;
    send_byte(b);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = b0[4] ? int'(b1) - 256 : int'(b1);
    dy = b0[5] ? int'(b2) - 256 : int'(b2);
    if (b0[6]) dx = 0;
    if (b0[7]) dy = 0;
    if (b0[6] || b0[7]) exp_err++;
    mx   = clampi(mx + dx, 639);
    my   = clampi(my - dy, 479);
    mbtn = b0[2:0];
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic check_writes(input int ex, input int ey, input logic [2:0] eb);
    int n = 0;
    logic [47:0] w;
    while (wq.size() < 2 && n < 300) begin
      cyc();
      n++;
    end
    chk("writes_seen", wq.size() >= 2, 1);
    if (wq.size() >= 2) begin
      w = wq.pop_front();
      chk("x_addr", w[47:32], 32'h0000);
      chk("x_data", w[31:0], ex);
      w = wq.pop_front();
      chk("y_addr", w[47:32], 32'h0010);
      chk("y_data", w[31:0], ey);
    end
    if (!rand_stall)
      chk("rdy_after_wr", rx_ready, 1);
    chk("buttons", buttons, eb);
    chk("pkt_err_cnt", err_cnt, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] b0;
    reset_n       = 1'b0;
    rx_valid      = 1'b0;
    rx_data       = 8'h00;
    m_waitrequest = 1'b0;
    cyc();
    cyc();
    chk("rst_cs", m_chipselect, 1);
    chk("rst_wn", m_write_n, 0);
    chk("rst_addr", m_address, 16'h0000);
    chk("rst_data", m_writedata, 320);
    chk("rst_rdy", rx_ready, 0);
    chk("rst_btn", buttons, 0);
    chk("rst_err", pkt_err, 0);
    reset_n = 1'b1;
    check_writes(320, 240, 3'b000);
    chk("idle_cs", m_chipselect, 0);
    chk("idle_wn", m_write_n, 1);
    chk("idle_addr", m_address, 0);
    chk("idle_data", m_writedata, 0);

    send_pkt(8'h08, 8'h0A, 8'h05); check_writes(330, 235, 3'b000);
    send_pkt(8'h19, 8'hF6, 8'h00); check_writes(320, 235, 3'b001);
    send_pkt(8'h08, 8'hFF, 8'h00); check_writes(575, 235, 3'b000);
    send_pkt(8'h08, 8'h37, 8'h00); check_writes(630, 235, 3'b000);
    send_pkt(8'h08, 8'h14, 8'h00); check_writes(639, 235, 3'b000);
    send_pkt(8'h28, 8'h00, 8'h0D); check_writes(639, 478, 3'b000);
    send_pkt(8'h28, 8'h00, 8'hFB); check_writes(639, 479, 3'b000);
    send_pkt(8'h18, 8'h9C, 8'h00); check_writes(539, 479, 3'b000);
    send_junk(8'h00);
    send_pkt(8'h08, 8'h0A, 8'h00); check_writes(549, 479, 3'b000);
    send_pkt(8'h48, 8'hFF, 8'h03); check_writes(549, 476, 3'b000);
    send_pkt(8'h18, 8'h00, 8'hFF); check_writes(293, 221, 3'b000);
    send_pkt(8'h18, 8'h00, 8'hFF); check_writes(37, 0, 3'b000);
    send_pkt(8'h18, 8'h00, 8'hFF); check_writes(0, 0, 3'b000);

    // Stall the X write for three edges
    send_pkt(8'h28, 8'h05, 8'hFB);
    n = 0;
    while (!(m_chipselect && m_address == 16'h0000) && n < 20) begin
      cyc();
      n++;
    end
    m_waitrequest = 1'b1;
    chk("stall_enter_data", m_writedata, 5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_hold_cs", m_chipselect, 1);
      chk("stall_hold_addr", m_address, 16'h0000);
      chk("stall_hold_data", m_writedata, 5);
      if (i == 2) m_waitrequest = 1'b0;
    end
    cyc();
    chk("y_follows_addr", m_address, 16'h0010);
    check_writes(5, 5, 3'b000);

    // Reset in the middle of the Y write
    send_pkt(8'h08, 8'h64, 8'h00);
    n = 0;
    while (!(m_chipselect && m_address == 16'h0010) && n < 20) begin
      cyc();
      n++;
    end
    chk("reached_wr_y", m_address, 16'h0010);
    reset_n = 1'b0;
    #1;
    chk("midrst_addr", m_address, 16'h0000);
    chk("midrst_data", m_writedata, 320);
    chk("midrst_cs", m_chipselect, 1);
    chk("midrst_rdy", rx_ready, 0);
    wq.delete();
    mx = 320; my = 240; mbtn = 3'b000;
    cyc();
    reset_n = 1'b1;
    check_writes(320, 240, 3'b000);

    // Randomized traffic with random bus stalls
    rand_stall = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0)
        send_junk(8'($urandom_range(0, 255)) & 8'hF7);
      b0 = 8'($urandom_range(0, 255)) | 8'h08;
      if ($urandom_range(0, 5) != 0) b0[7:6] = 2'b00;
      send_pkt(b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      check_writes(mx, my, mbtn);
    end
    rand_stall = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
